// File: rtl/fifo_reader.sv
// FIFO drain side: issues reads, buffers words in a 2-entry skid buffer, frames bursts.
// Optional FIFO_RD_PARITY_EN adds out_par, the even parity of out_data.
module fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_wr_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
`ifdef FIFO_RD_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic             pend_q;
    logic [7:0]       beat_q, beat_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;

    logic       pop;
    logic       wr_win;
    logic       acc;
    logic [2:0] fill_lvl;

    assign pop      = out_valid & out_ready;
    assign fill_lvl = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};

    // Reads are suppressed while reset is held so nothing is in flight on release.
    assign fifo_rd_en = reset & en & ~fifo_empty & (fill_lvl < 3'd2);

    // The FIFO drops a read that coincides with an accepted write.
    assign wr_win = fifo_wr_en & ~fifo_full;
    assign acc    = fifo_rd_en & ~wr_win;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign out_last  = out_valid & (beat_q == LAST);

`ifdef FIFO_RD_PARITY_EN
    assign out_par = out_valid & (^out_data);
`endif

    always_comb begin
        occ_d  = fill_lvl[1:0];
        beat_d = beat_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
            beat_d = (beat_q == LAST) ? 8'd0 : beat_q + 8'd1;
        end
        // Arriving word lands in the slot just past the surviving entries.
        if (pend_q) begin
            if (fill_lvl[1:0] == 2'd1) begin
                buf0_d = fifo_dout;
            end else begin
                buf1_d = fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            beat_q <= 8'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= acc;
            beat_q <= beat_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO and scoreboard plus directed scenarios.
module tb_fifo_reader;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_rd_en;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
`ifdef FIFO_RD_PARITY_EN
    logic       out_par;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int npop = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       last_q[$];
    int         pc_q[$];
    logic       stall_q = 1'b0;
    logic [7:0] held = 8'h00;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(8), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FIFO_RD_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model, depth 16, write wins over read.
    always @(posedge clk) begin : fifo_m
        logic wacc;
        logic [7:0] w;
        wacc = fifo_wr_en && !fifo_full;
        if (fifo_rd_en && !wacc) begin
            if (fq.size() == 0) begin
                chk("rd_on_empty", 1, 0);
            end else begin
                w = fq.pop_front();
                fifo_dout <= w;
                if (reset) exp_q.push_back(w);
            end
        end
        if (wacc) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() >= 16);
    end

    // Scoreboard: order, framing, bound on outstanding words, stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            npop = 0;
            stall_q = 1'b0;
        end else begin
            if (exp_q.size() > 2) chk("outstanding", exp_q.size(), 2);
            if (stall_q) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(held));
            end
            if (out_valid) begin
                chk("last", int'(out_last), int'((npop % BL) == BL - 1));
`ifdef FIFO_RD_PARITY_EN
                chk("par", int'(out_par), int'(^out_data));
`endif
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("dup_word", int'(out_data), -1);
                    end else begin
                        chk("order", int'(out_data), int'(exp_q.pop_front()));
                    end
                    got_q.push_back(out_data);
                    last_q.push_back(out_last);
                    pc_q.push_back(cyc);
                    npop++;
                end
            end
`ifdef FIFO_RD_PARITY_EN
            else chk("par_idle", int'(out_par), 0);
`endif
            stall_q = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got_q.delete();
        last_q.delete();
        pc_q.delete();
    endtask

    task automatic fill(input logic [7:0] d[]);
        foreach (d[i]) begin
            fifo_wr_en = 1'b1;
            wr_data = d[i];
            step();
        end
        fifo_wr_en = 1'b0;
        step();
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, int'(n >= 60), 0);
        @(negedge clk);
        chk({nm, "_idle"}, int'(out_valid), 0);
    endtask

    task automatic chk_seq(string nm, input logic [7:0] e[]);
        chk({nm, "_count"}, got_q.size(), e.size());
        foreach (e[i]) begin
            if (i < got_q.size()) chk({nm, "_word"}, int'(got_q[i]), int'(e[i]));
        end
    endtask

    task automatic chk_b2b(string nm);
        if (pc_q.size() > 0)
            chk({nm, "_b2b"}, pc_q[pc_q.size()-1] - pc_q[0], pc_q.size() - 1);
    endtask

    initial begin
        int first_rd, last_rd, first_v, rdcnt;

        #1 reset = 1'b0;
        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_rd_en", int'(fifo_rd_en), 0);
        step();
        reset = 1'b1;
        step();

        // Three words, free-flowing consumer
        clr();
        fill('{8'h11, 8'h22, 8'h33});
        en = 1'b1;
        out_ready = 1'b1;
        first_rd = -1; last_rd = -1; first_v = -1; rdcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                rdcnt++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (out_valid && first_v < 0) first_v = i;
        end
        chk("t2_rd_cnt", rdcnt, 3);
        chk("t2_rd_span", last_rd - first_rd, 2);
        chk("t2_latency", first_v - first_rd, 2);
        wait_idle("t2");
        chk_seq("t2", '{8'h11, 8'h22, 8'h33});
        chk_b2b("t2");

        // Stalled consumer: only two reads outstanding
        clr();
        en = 1'b0;
        out_ready = 1'b0;
        step();
        fill('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});
        en = 1'b1;
        rdcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rdcnt++;
        end
        chk("t3_rd_cnt", rdcnt, 2);
        chk("t3_rd_off", int'(fifo_rd_en), 0);
        chk("t3_head", int'(out_data), 8'hA1);
        step();
        out_ready = 1'b1;
        wait_idle("t3");
        chk_seq("t3", '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});

        // Write collides with the first read
        clr();
        en = 1'b0;
        step();
        fill('{8'hB1, 8'hB2});
        en = 1'b1;
        out_ready = 1'b1;
        fifo_wr_en = 1'b1;
        wr_data = 8'hB3;
        @(negedge clk);
        chk("t4_rd_req", int'(fifo_rd_en), 1);
        step();
        fifo_wr_en = 1'b0;
        chk("t4_fifo_lvl", fq.size(), 3);
        @(negedge clk);
        chk("t4_reissue", int'(fifo_rd_en), 1);
        wait_idle("t4");
        chk_seq("t4", '{8'hB1, 8'hB2, 8'hB3});
        chk_b2b("t4");

        // Reset mid-stream with a full skid buffer
        clr();
        en = 1'b0;
        out_ready = 1'b0;
        step();
        fill('{8'hC1, 8'hC2, 8'hC3, 8'hC4});
        en = 1'b1;
        repeat (4) step();
        chk("t1_pre_valid", int'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_rd_en", int'(fifo_rd_en), 0);
        chk("t1_data", int'(out_data), 0);
        chk("t1_last", int'(out_last), 0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        wait_idle("t1");
        chk_seq("t1", '{8'hC3, 8'hC4});
        if (last_q.size() == 2) begin
            chk("t1_beat0", int'(last_q[0]), 0);
            chk("t1_beat1", int'(last_q[1]), 0);
        end

        // Burst framing over two bursts
        clr();
        en = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        fill('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        en = 1'b1;
        wait_idle("t5");
        chk_seq("t5", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        for (int i = 0; i < last_q.size(); i++)
            chk("t5_last", int'(last_q[i]), int'(i == 3 || i == 7));

`ifdef FIFO_RD_PARITY_EN
        clr();
        en = 1'b0;
        out_ready = 1'b0;
        step();
        fill('{8'h07, 8'h03});
        en = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t6_head7", int'(out_data), 8'h07);
        chk("t6_par7", int'(out_par), 1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_head3", int'(out_data), 8'h03);
        chk("t6_par3", int'(out_par), 0);
        step();
        out_ready = 1'b1;
        wait_idle("t6");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
